motor_pwm_gen: RTL and testbench

- Consumes the 8-bit duty word from the motor duty PIO output port and drives one H-bridge channel (IN1/IN2) with a fixed-frequency PWM.
- Direction input comes from a sibling direction PIO.
- Duty is applied glitch-free at period boundaries.
- Dead time is enforced on every direction reversal.
- One instance per motor; it sits between the Avalon PIO register and the FPGA motor pins.

---
 rtl/motor_pwm_pkg.sv | 41 ++++
 rtl/motor_pwm_tick.sv | 32 +++
 rtl/motor_pwm_gen.sv | 146 ++++++++++++++
 tb/tb_motor_pwm_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: shared types and constants for the motor PWM channel.
// Holds the channel FSM encoding, the period terminal count, the duty width
// and the duty slew helper used when MOTOR_PWM_SLEW_EN is defined.
package motor_pwm_pkg;

    localparam int DUTY_W = 8;

    // Last value of the period counter; a period is 0..254, i.e. 255 ticks.
    localparam logic [DUTY_W-1:0] PWM_PERIOD_MAX = 8'd254;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } pwm_state_t;

    // Move cur toward tgt by at most step. Done in 9 bits so the sum cannot
    // wrap, then clamped to tgt so the result never overshoots.
    function automatic logic [DUTY_W-1:0] slew_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input int                step
    );
        logic [DUTY_W:0] cur9;
        logic [DUTY_W:0] tgt9;
        logic [DUTY_W:0] step9;
        logic [DUTY_W:0] res9;
        cur9  = {1'b0, cur};
        tgt9  = {1'b0, tgt};
        step9 = (DUTY_W + 1)'(step);
        if (tgt9 > cur9) begin
            res9 = cur9 + step9;
            if (res9 > tgt9) res9 = tgt9;
        end else begin
            if ((cur9 - tgt9) > step9) res9 = cur9 - step9;
            else                       res9 = tgt9;
        end
        return res9[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/motor_pwm_tick.sv
// motor_pwm_tick: PWM prescaler. Counts 0..CLK_DIV-1 and flags the last
// count as a one-cycle tick; clear forces the count back to 0.
module motor_pwm_tick #(
    parameter int CLK_DIV = 196
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler_q;
    logic [PW-1:0] prescaler_d;

    assign tick = (prescaler_q == LAST);

    // Next prescaler value: wrap after the tick, restart on clear.
    always_comb begin
        prescaler_d = prescaler_q + PW'(1);
        if (clear || tick) prescaler_d = '0;
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prescaler_q <= '0;
        else          prescaler_q <= prescaler_d;
    end

endmodule

// File: rtl/motor_pwm_gen.sv
// motor_pwm_gen: one H-bridge channel. Fixed-frequency PWM from an 8-bit
// duty word, duty latched only at period boundaries, dead time on every
// direction reversal. Define MOTOR_PWM_SLEW_EN to limit the duty change per
// period to SLEW_STEP.
module motor_pwm_gen
    import motor_pwm_pkg::*;
#(
    parameter int CLK_DIV    = 196,
    parameter int DEAD_TICKS = 8,
    parameter int SLEW_STEP  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] duty,
    input  logic       dir,
    output logic       pwm_a,
    output logic       pwm_b,
    output logic       period_start,
    output logic       dead_active
);

    localparam int DEAD_W = $clog2(DEAD_TICKS + 1);

    pwm_state_t        state_q, state_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [DUTY_W-1:0] duty_shadow_q, duty_shadow_d;
    logic              dir_act_q, dir_act_d;
    logic              pwm_a_q, pwm_a_d;
    logic              pwm_b_q, pwm_b_d;
    logic              period_start_q, period_start_d;

    logic tick;
    logic clear;
    logic wrap;
    logic go_dead;
    logic dead_done;
    logic pwm_int;

    // Disable has priority over a reversal; a reversal only counts while enabled.
    assign wrap      = (state_q == RUN) && tick && (cnt_q == PWM_PERIOD_MAX);
    assign go_dead   = (state_q == RUN) && enable && (dir != dir_act_q);
    assign dead_done = (state_q == DEAD) && enable && tick && (dead_cnt_q == DEAD_W'(1));
    assign clear     = (state_q == IDLE) || go_dead;

    motor_pwm_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .tick    (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
                     else if (go_dead) state_d = DEAD;
            DEAD:    if (!enable) state_d = IDLE;
                     else if (dead_done) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: PWM legs and the period-start pulse, registered below.
    always_comb begin
        pwm_int        = (state_q == RUN) && (cnt_q < duty_shadow_q);
        pwm_a_d        = pwm_int & ~dir_act_q;
        pwm_b_d        = pwm_int & dir_act_q;
        period_start_d = ((state_q == IDLE) && enable) || dead_done ||
                         (wrap && (state_d == RUN));
    end

    assign dead_active = (state_q == DEAD);

    // Period counter, dead-time counter, duty shadow and latched direction.
    always_comb begin
        cnt_d         = cnt_q;
        dead_cnt_d    = dead_cnt_q;
        duty_shadow_d = duty_shadow_q;
        dir_act_d     = dir_act_q;

        if (state_q != RUN)  cnt_d = '0;
        else if (wrap)       cnt_d = '0;
        else if (tick)       cnt_d = cnt_q + DUTY_W'(1);

        if (go_dead)
            dead_cnt_d = DEAD_W'(DEAD_TICKS);
        else if ((state_q == DEAD) && tick && (dead_cnt_q != '0))
            dead_cnt_d = dead_cnt_q - DEAD_W'(1);
        else if (state_q == IDLE)
            dead_cnt_d = '0;

        if ((state_q == IDLE) || dead_done) dir_act_d = dir;

`ifdef MOTOR_PWM_SLEW_EN
        // Every fresh start ramps up from 0.
        if (state_q == IDLE)  duty_shadow_d = enable ? '0 : duty;
        else if (dead_done)   duty_shadow_d = '0;
        else if (wrap)        duty_shadow_d = slew_toward(duty_shadow_q, duty, SLEW_STEP);
`else
        if ((state_q == IDLE) || dead_done || wrap) duty_shadow_d = duty;
`endif
    end

`ifndef MOTOR_PWM_SLEW_EN
    logic unused_slew_step;
    assign unused_slew_step = ^SLEW_STEP;
`endif

    // Datapath and output registers; reset drops the legs asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            dead_cnt_q     <= '0;
            duty_shadow_q  <= '0;
            dir_act_q      <= 1'b0;
            pwm_a_q        <= 1'b0;
            pwm_b_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            dead_cnt_q     <= dead_cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            dir_act_q      <= dir_act_d;
            pwm_a_q        <= pwm_a_d;
            pwm_b_q        <= pwm_b_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_a        = pwm_a_q;
    assign pwm_b        = pwm_b_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_motor_pwm_gen.sv
// tb_motor_pwm_gen: directed bench for motor_pwm_gen with CLK_DIV=2,
// DEAD_TICKS=8. A monitor measures each PWM period window (length, high
// cycles on each leg) and checks it against a queue of expected windows.
module tb_motor_pwm_gen;

    localparam int W = 48;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] duty;
    logic       dir;
    logic       pwm_a;
    logic       pwm_b;
    logic       period_start;
    logic       dead_active;

    logic [W-1:0] exp_q[$];
    int n_checks  = 0;
    int n_pass    = 0;
    int excl_viol = 0;
    bit discard   = 1'b0;

    motor_pwm_gen #(
        .CLK_DIV    (2),
        .DEAD_TICKS (8),
        .SLEW_STEP  (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .duty         (duty),
        .dir          (dir),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .period_start (period_start),
        .dead_active  (dead_active)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic void push_win(input int len, input int ha, input int hb);
        exp_q.push_back({16'(len), 16'(ha), 16'(hb)});
    endfunction

    task automatic wait_ps();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!period_start && k < 2000);
        if (!period_start) check("period_start_timeout", int'(period_start), 1);
    endtask

    // monitor / scoreboard: a window runs from the cycle after one
    // period_start pulse up to and including the next pulse, which matches
    // the one-cycle register latency of the legs.
    initial begin : monitor
        logic         ps_last;
        bit           in_period;
        int           len, ha, hb;
        logic [W-1:0] exp_w;
        ps_last   = 1'b0;
        in_period = 1'b0;
        len = 0; ha = 0; hb = 0;
        forever begin
            @(negedge clk);
            if (ps_last) begin
                if (in_period) begin
                    if (discard) begin
                        discard = 1'b0;
                    end else if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL window_unexpected: actual len=%0d a=%0d b=%0d required none",
                                 len, ha, hb);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("window_len",  len, int'(exp_w[47:32]));
                        check("window_hi_a", ha,  int'(exp_w[31:16]));
                        check("window_hi_b", hb,  int'(exp_w[15:0]));
                    end
                end
                in_period = 1'b1;
                len = 0; ha = 0; hb = 0;
            end
            len++;
            if (pwm_a) ha++;
            if (pwm_b) hb++;
            if (pwm_a && pwm_b) excl_viol++;
            ps_last = period_start;
        end
    end

    // driver
    initial begin : driver
        int dcount;
        int zcount;
        reset_n = 1'b0;
        enable  = 1'b0;
        duty    = 8'd64;
        dir     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm_a",        int'(pwm_a),        0);
        check("rst_pwm_b",        int'(pwm_b),        0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_dead_active",  int'(dead_active),  0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_pwm_a",        int'(pwm_a),        0);
        check("idle_period_start", int'(period_start), 0);

        // duty 64 forward: 128 high clk per 510-clk period
        enable = 1'b1;
        push_win(510, 128, 0);
        push_win(510, 128, 0);
        push_win(510, 128, 0);
        wait_ps(); wait_ps(); wait_ps();

        // mid-period change 64 -> 200: current period unchanged, next 400
        repeat (100) @(negedge clk);
        duty = 8'd200;
        push_win(510, 400, 0);
        wait_ps();

        // duty 0 for two periods
        repeat (50) @(negedge clk);
        duty = 8'd0;
        push_win(510, 0, 0);
        push_win(510, 0, 0);
        wait_ps(); wait_ps();

        // duty 255 for two periods: no gaps
        repeat (50) @(negedge clk);
        duty = 8'd255;
        push_win(510, 510, 0);
        push_win(510, 510, 0);
        wait_ps(); wait_ps();

        // back to 64 for the reversal test
        repeat (50) @(negedge clk);
        duty = 8'd64;
        wait_ps();

        // reversal at the first cycle of a period: one high clk on pwm_a,
        // 16 clk dead, then pwm_b carries the duty
        dir = 1'b1;
        push_win(17, 1, 0);
        push_win(510, 0, 128);
        dcount = 0;
        zcount = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dead_active) dcount++;
            if (i >= 2 && i <= 17 && !pwm_a && !pwm_b) zcount++;
            if (i == 18) check("pwm_b_after_dead", int'(pwm_b), 1);
        end
        check("dead_active_clk", dcount, 16);
        check("dead_zero_clk",   zcount, 16);
        wait_ps();

        // enable dropped during dead time
        dir = 1'b0;
        repeat (3) @(negedge clk);
        check("dead_before_disable", int'(dead_active), 1);
        discard = 1'b1;
        enable  = 1'b0;
        @(negedge clk);
        check("disable_dead_active", int'(dead_active), 0);
        check("disable_pwm_a",       int'(pwm_a),       0);
        check("disable_pwm_b",       int'(pwm_b),       0);
        repeat (5) @(negedge clk);
        check("disable_no_period", int'(period_start), 0);
        enable = 1'b1;
        push_win(510, 128, 0);
        wait_ps(); wait_ps();

        // reset in the middle of a high pulse
        repeat (20) @(negedge clk);
        discard = 1'b1;
        check("pre_reset_pwm_a", int'(pwm_a), 1);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_pwm_a",        int'(pwm_a),        0);
        check("async_rst_pwm_b",        int'(pwm_b),        0);
        check("async_rst_period_start", int'(period_start), 0);
        check("async_rst_dead_active",  int'(dead_active),  0);
        @(negedge clk);
        reset_n = 1'b1;
        push_win(510, 128, 0);
        wait_ps(); wait_ps();
        repeat (3) @(negedge clk);

        check("exp_q_drained",  exp_q.size(), 0);
        check("legs_exclusive", excl_viol,    0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
